demux41_tdm: RTL and testbench
==============================

# demux41_tdm

Registered 1:4 time-division demultiplexer: the receive end of a 4:1 mux stream in which one WIDTH-bit word is sent per beat, tagged with its 2-bit channel select. It reassembles four consecutive beats (sel 0,1,2,3) into one frame on outputs a..d. It raises frame_valid with a valid/ready handshake and flags out-of-order selects. It sits between the serial mux link and the consumer of the parallel 4-lane word.

## Interface
- WIDTH, 4, data width of each lane and of in_data
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  beat present on in_data/in_sel
- in_ready  out  1  block accepts beat this cycle
- in_data  in  WIDTH  beat payload
- in_sel  in  2  channel tag of beat (0=a, 1=b, 2=c, 3=d)
- a, b, c, d  out  WIDTH each  assembled frame lanes, registered
- frame_valid  out  1  a..d hold a complete frame
- frame_ready  in  1  consumer takes frame
- seq_err  out  1  one-cycle pulse on sequence violation

## Operation
- Accept = in_valid & in_ready; nothing changes on a non-accepted cycle.
- Staging registers s0..s3 are separate from the output registers a..d. Lanes 0-2 stage while the previous frame is still held.
- exp_ch is a 2-bit expected-channel counter.
- in_ready = ~(state==COLLECT & exp_ch==3 & frame_valid & ~frame_ready). Only the frame-completing beat stalls. The combinational path frame_ready->in_ready is permitted.
- State HUNT: on accept with sel==0, write s0, set exp_ch=1, and go to COLLECT. Accepts with sel!=0 are dropped silently, with no seq_err.
- State COLLECT, accept with sel==exp_ch, exp_ch<3: write s[exp_ch] and increment exp_ch.
- State COLLECT, accept with sel==exp_ch==3:
  - load a..d <= s0,s1,s2,in_data;
  - set frame_valid=1, exp_ch=0, and go to HUNT.
- State COLLECT, accept with sel!=exp_ch:
  - pulse seq_err and discard the partial frame;
  - if sel==0, write s0, set exp_ch=1, and stay in COLLECT;
  - otherwise, set exp_ch=0 and go to HUNT.
- frame_valid clears on frame_valid & frame_ready. If a completion beat is accepted in the same cycle, frame_valid stays 1 and a..d take the new frame.
- a..d change only on a completion load and are stable while frame_valid=1.

## Timing
- Reset (asynchronous, rst_n=0):
  - a=b=c=d=0, frame_valid=0, seq_err=0;
  - state=HUNT, exp_ch=0, s0..s3=0;
  - in_ready=1 after reset.
- Latency: when the sel==3 beat is accepted on edge N, a..d and frame_valid are valid after edge N (one register stage).
- Minimum frame period is 4 cycles at in_valid=1 with back-to-back frames and frame_ready=1.
- seq_err asserts for exactly one cycle after the offending accept edge.
- Reset asserted mid-frame discards staging. The first frame after release must start with sel==0.

## Configuration
- DEMUX41_SEQ_CHECK_EN defined: behaviour is as in Operation, with HUNT/COLLECT sequencing and seq_err.
- DEMUX41_SEQ_CHECK_EN undefined:
  - no sequence checking, and sel addresses staging directly in any order;
  - accepting a sel==3 beat completes the frame, using whatever s0..s2 currently hold;
  - seq_err is tied to 0 and state stays in COLLECT;
  - the in_ready stall applies to every sel==3 beat.

## Structure
- Package demux41_pkg holds:
  - the state enum (HUNT, COLLECT);
  - NUM_CH=4 and the channel index constants CH_A..CH_D.
- Sub-module demux41_lane_reg is a WIDTH-bit register with async reset and load enable. It is instantiated for s0..s3 and for a..d.

## Test plan
- Reset, then sel 0,1,2,3 with data 1,2,4,8 and frame_ready=1 -> after the 4th edge, a=1, b=2, c=4, d=8, frame_valid=1 for 1 cycle, seq_err=0.
- Continuous sel increment every cycle, with data changing from 1,2,4,8 to C,3,6,9 -> two frames 4 cycles apart, both captured intact.
- frame_ready=0 while the second frame's beats arrive:
  - sel 0-2 are accepted;
  - in_ready=0 on the sel==3 beat;
  - a..d stay 1,2,4,8 until frame_ready=1, then the new frame loads in the same cycle.
- Stream sel 0,1,3 -> seq_err pulses once, no frame, and the block returns to HUNT. A following 0,1,2,3 with C,3,6,9 produces a=C, d=9.
- After reset, sel 2,3 then 0,1,2,3 -> the first two beats are dropped with no seq_err, and one frame follows.
- rst_n pulsed low after sel 0,1 -> all outputs 0 immediately, and a subsequent full frame is captured correctly.

Source files
------------

// File: rtl/demux41_pkg.sv
// Shared types and channel constants for the demux41 TDM receive path.
package demux41_pkg;

  typedef enum logic {
    HUNT    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  localparam int NUM_CH = 4;

  localparam logic [1:0] CH_A = 2'd0;
  localparam logic [1:0] CH_B = 2'd1;
  localparam logic [1:0] CH_C = 2'd2;
  localparam logic [1:0] CH_D = 2'd3;

endpackage

// File: rtl/demux41_lane_reg.sv
// WIDTH-bit lane register with asynchronous active-low reset and load enable.
module demux41_lane_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Hold value unless loaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= {WIDTH{1'b0}};
    end else if (load) begin
      q <= d;
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/demux41_tdm.sv
// Registered 1:4 TDM demultiplexer reassembling sel-tagged beats into a..d frames.
// Define DEMUX41_SEQ_CHECK_EN for HUNT/COLLECT sequencing with seq_err reporting.
module demux41_tdm
  import demux41_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic             frame_valid,
  input  logic             frame_ready,
  output logic             seq_err
);

  logic              accept_s;
  logic [NUM_CH-1:0] stage_we_s;
  logic              frame_load_s;
  logic              seq_err_s;
  logic [WIDTH-1:0]  stage_r  [NUM_CH];
  logic [WIDTH-1:0]  merged_s [NUM_CH];
  logic [WIDTH-1:0]  lane_r   [NUM_CH];
  logic              frame_valid_r;
  logic              seq_err_r;

  assign accept_s = in_valid & in_ready;

`ifdef DEMUX41_SEQ_CHECK_EN
  state_t     state_r;
  state_t     state_nxt_s;
  logic [1:0] exp_ch_r;
  logic [1:0] exp_ch_nxt_s;

  // Only the frame-completing beat stalls while the held frame is unconsumed.
  assign in_ready = ~((state_r == COLLECT) && (exp_ch_r == CH_D) && frame_valid_r && !frame_ready);

  // Sequencing decisions for the accepted beat.
  always_comb begin
    state_nxt_s  = state_r;
    exp_ch_nxt_s = exp_ch_r;
    stage_we_s   = {NUM_CH{1'b0}};
    frame_load_s = 1'b0;
    seq_err_s    = 1'b0;
    if (accept_s) begin
      case (state_r)
        HUNT: begin
          if (in_sel == CH_A) begin
            stage_we_s[CH_A] = 1'b1;
            exp_ch_nxt_s     = CH_B;
            state_nxt_s      = COLLECT;
          end else begin
            state_nxt_s = HUNT;
          end
        end
        COLLECT: begin
          if (in_sel == exp_ch_r) begin
            stage_we_s[in_sel] = 1'b1;
            if (exp_ch_r == CH_D) begin
              frame_load_s = 1'b1;
              exp_ch_nxt_s = CH_A;
              state_nxt_s  = HUNT;
            end else begin
              exp_ch_nxt_s = exp_ch_r + 2'd1;
            end
          end else begin
            seq_err_s = 1'b1;
            // A stray sel 0 is treated as the start of a fresh frame.
            if (in_sel == CH_A) begin
              stage_we_s[CH_A] = 1'b1;
              exp_ch_nxt_s     = CH_B;
            end else begin
              exp_ch_nxt_s = CH_A;
              state_nxt_s  = HUNT;
            end
          end
        end
        default: begin
          exp_ch_nxt_s = CH_A;
          state_nxt_s  = HUNT;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Sequencer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= HUNT;
      exp_ch_r <= 2'd0;
    end else begin
      state_r  <= state_nxt_s;
      exp_ch_r <= exp_ch_nxt_s;
    end
  end
`else
  assign in_ready = ~((in_sel == CH_D) && frame_valid_r && !frame_ready);

  // Unchecked mode: sel addresses staging directly, sel 3 completes the frame.
  always_comb begin
    stage_we_s   = {NUM_CH{1'b0}};
    frame_load_s = 1'b0;
    seq_err_s    = 1'b0;
    if (accept_s) begin
      stage_we_s[in_sel] = 1'b1;
      frame_load_s       = (in_sel == CH_D);
    end else begin
      frame_load_s = 1'b0;
    end
  end
`endif

  // Frame lanes take staging with the current beat merged in.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      merged_s[i] = stage_we_s[i] ? in_data : stage_r[i];
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
    demux41_lane_reg #(.WIDTH(WIDTH)) u_stage (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (stage_we_s[g]),
      .d     (in_data),
      .q     (stage_r[g])
    );
    demux41_lane_reg #(.WIDTH(WIDTH)) u_out (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (frame_load_s),
      .d     (merged_s[g]),
      .q     (lane_r[g])
    );
  end

  // A new frame load wins over consumption of the held one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_valid_r <= 1'b0;
      seq_err_r     <= 1'b0;
    end else begin
      seq_err_r <= seq_err_s;
      if (frame_load_s) begin
        frame_valid_r <= 1'b1;
      end else if (frame_valid_r && frame_ready) begin
        frame_valid_r <= 1'b0;
      end else begin
        frame_valid_r <= frame_valid_r;
      end
    end
  end

  assign a           = lane_r[CH_A];
  assign b           = lane_r[CH_B];
  assign c           = lane_r[CH_C];
  assign d           = lane_r[CH_D];
  assign frame_valid = frame_valid_r;
  assign seq_err     = seq_err_r;

endmodule

// File: tb/tb_demux41_tdm.sv
// Directed table-driven bench for demux41_tdm; frame is compared as {a,b,c,d}.
module tb_demux41_tdm;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic [1:0] in_sel;
  logic [3:0] a, b, c, d;
  logic       frame_valid;
  logic       frame_ready;
  logic       seq_err;

  int errors = 0;
  int checks = 0;

  demux41_tdm #(.WIDTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_sel      (in_sel),
    .a           (a),
    .b           (b),
    .c           (c),
    .d           (d),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .seq_err     (seq_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [1:0]  sel;
    logic [3:0]  dat;
    logic        fr;
    logic        e_rdy;
    logic [15:0] e_frame;
    logic        e_fv;
    logic        e_err;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One beat: drive at negedge, check ready before the edge, outputs after it.
  task automatic beat(input string nm, input logic v, input logic [1:0] sel,
                      input logic [3:0] dat, input logic fr, input logic e_rdy,
                      input logic [15:0] e_frame, input logic e_fv, input logic e_err);
    @(negedge clk);
    in_valid    = v;
    in_sel      = sel;
    in_data     = dat;
    frame_ready = fr;
    #1;
    chk({nm, ".in_ready"}, {15'd0, in_ready}, {15'd0, e_rdy});
    @(posedge clk);
    #1;
    chk({nm, ".frame"}, {a, b, c, d}, e_frame);
    chk({nm, ".frame_valid"}, {15'd0, frame_valid}, {15'd0, e_fv});
    chk({nm, ".seq_err"}, {15'd0, seq_err}, {15'd0, e_err});
  endtask

  task automatic chk_idle_outputs(input string nm);
    chk({nm, ".in_ready"}, {15'd0, in_ready}, 16'd1);
    chk({nm, ".frame"}, {a, b, c, d}, 16'h0000);
    chk({nm, ".frame_valid"}, {15'd0, frame_valid}, 16'd0);
    chk({nm, ".seq_err"}, {15'd0, seq_err}, 16'd0);
  endtask

  initial begin
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_sel      = 2'd0;
    in_data     = 4'h0;
    frame_ready = 1'b1;

    // v, sel, data, frame_ready, exp in_ready, exp {a,b,c,d}, exp frame_valid, exp seq_err
    vecs[0]  = '{1'b1, 2'd0, 4'h1, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 2'd1, 4'h2, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 2'd2, 4'h4, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 2'd3, 4'h8, 1'b1, 1'b1, 16'h1248, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 2'd0, 4'hC, 1'b1, 1'b1, 16'h1248, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 2'd1, 4'h3, 1'b1, 1'b1, 16'h1248, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 2'd2, 4'h6, 1'b1, 1'b1, 16'h1248, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 2'd3, 4'h9, 1'b1, 1'b1, 16'hC369, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 2'd0, 4'h1, 1'b0, 1'b1, 16'hC369, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 2'd1, 4'h2, 1'b0, 1'b1, 16'hC369, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 2'd2, 4'h4, 1'b0, 1'b1, 16'hC369, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 2'd3, 4'h8, 1'b0, 1'b0, 16'hC369, 1'b1, 1'b0};
    vecs[12] = '{1'b1, 2'd3, 4'h8, 1'b0, 1'b0, 16'hC369, 1'b1, 1'b0};
    vecs[13] = '{1'b1, 2'd3, 4'h8, 1'b1, 1'b1, 16'h1248, 1'b1, 1'b0};
    vecs[14] = '{1'b0, 2'd0, 4'h0, 1'b1, 1'b1, 16'h1248, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 2'd3, 4'hF, 1'b0, 1'b1, 16'h1248, 1'b0, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk_idle_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      beat($sformatf("vec%0d", i), vecs[i].v, vecs[i].sel, vecs[i].dat, vecs[i].fr,
           vecs[i].e_rdy, vecs[i].e_frame, vecs[i].e_fv, vecs[i].e_err);
    end

`ifdef DEMUX41_SEQ_CHECK_EN
    // 0,1,3: error pulse, no frame, back to HUNT; then a clean frame.
    beat("skip0", 1'b1, 2'd0, 4'h1, 1'b1, 1'b1, 16'h1248, 1'b0, 1'b0);
    beat("skip1", 1'b1, 2'd1, 4'h2, 1'b1, 1'b1, 16'h1248, 1'b0, 1'b0);
    beat("skip3", 1'b1, 2'd3, 4'h8, 1'b1, 1'b1, 16'h1248, 1'b0, 1'b1);
    beat("skipidle", 1'b0, 2'd0, 4'h0, 1'b1, 1'b1, 16'h1248, 1'b0, 1'b0);
    beat("after0", 1'b1, 2'd0, 4'hC, 1'b1, 1'b1, 16'h1248, 1'b0, 1'b0);
    beat("after1", 1'b1, 2'd1, 4'h3, 1'b1, 1'b1, 16'h1248, 1'b0, 1'b0);
    beat("after2", 1'b1, 2'd2, 4'h6, 1'b1, 1'b1, 16'h1248, 1'b0, 1'b0);
    beat("after3", 1'b1, 2'd3, 4'h9, 1'b1, 1'b1, 16'hC369, 1'b1, 1'b0);
    // Stray sel 0 mid-frame restarts the frame.
    beat("rs0", 1'b1, 2'd0, 4'h1, 1'b1, 1'b1, 16'hC369, 1'b0, 1'b0);
    beat("rs1", 1'b1, 2'd1, 4'h2, 1'b1, 1'b1, 16'hC369, 1'b0, 1'b0);
    beat("rs0b", 1'b1, 2'd0, 4'h5, 1'b1, 1'b1, 16'hC369, 1'b0, 1'b1);
    beat("rs1b", 1'b1, 2'd1, 4'h6, 1'b1, 1'b1, 16'hC369, 1'b0, 1'b0);
    beat("rs2b", 1'b1, 2'd2, 4'h7, 1'b1, 1'b1, 16'hC369, 1'b0, 1'b0);
    beat("rs3b", 1'b1, 2'd3, 4'h8, 1'b1, 1'b1, 16'h5678, 1'b1, 1'b0);
`else
    // Unchecked mode: any order, sel 3 completes with current staging.
    beat("ooo2", 1'b1, 2'd2, 4'h5, 1'b1, 1'b1, 16'h1248, 1'b0, 1'b0);
    beat("ooo0", 1'b1, 2'd0, 4'h7, 1'b1, 1'b1, 16'h1248, 1'b0, 1'b0);
    beat("ooo1", 1'b1, 2'd1, 4'h6, 1'b1, 1'b1, 16'h1248, 1'b0, 1'b0);
    beat("ooo3", 1'b1, 2'd3, 4'hA, 1'b1, 1'b1, 16'h765A, 1'b1, 1'b0);
    beat("rep3", 1'b1, 2'd3, 4'hB, 1'b1, 1'b1, 16'h765B, 1'b1, 1'b0);
    beat("repidle", 1'b0, 2'd0, 4'h0, 1'b1, 1'b1, 16'h765B, 1'b0, 1'b0);
    beat("hold3a", 1'b1, 2'd3, 4'hC, 1'b0, 1'b1, 16'h765C, 1'b1, 1'b0);
    beat("hold3b", 1'b1, 2'd3, 4'hD, 1'b0, 1'b0, 16'h765C, 1'b1, 1'b0);
    beat("holdsel1", 1'b1, 2'd1, 4'hE, 1'b0, 1'b1, 16'h765C, 1'b1, 1'b0);
`endif

    // Reset mid-frame clears outputs asynchronously and discards staging.
    beat("pre0", 1'b1, 2'd0, 4'hF, 1'b1, 1'b1, {a, b, c, d}, 1'b0, 1'b0);
    beat("pre1", 1'b1, 2'd1, 4'hF, 1'b1, 1'b1, {a, b, c, d}, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("midreset");
    @(negedge clk);
    rst_n = 1'b1;

`ifdef DEMUX41_SEQ_CHECK_EN
    beat("drop2", 1'b1, 2'd2, 4'h2, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0);
    beat("drop3", 1'b1, 2'd3, 4'h3, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0);
`else
    beat("cleared3", 1'b1, 2'd3, 4'h8, 1'b1, 1'b1, 16'h0008, 1'b1, 1'b0);
`endif
    beat("post0", 1'b1, 2'd0, 4'h1, 1'b1, 1'b1, {a, b, c, d}, 1'b0, 1'b0);
    beat("post1", 1'b1, 2'd1, 4'h2, 1'b1, 1'b1, {a, b, c, d}, 1'b0, 1'b0);
    beat("post2", 1'b1, 2'd2, 4'h4, 1'b1, 1'b1, {a, b, c, d}, 1'b0, 1'b0);
    beat("post3", 1'b1, 2'd3, 4'h8, 1'b1, 1'b1, 16'h1248, 1'b1, 1'b0);
    beat("postidle", 1'b0, 2'd0, 4'h0, 1'b1, 1'b1, 16'h1248, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
